// File: rtl/alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer
//
// Operand-capture front end for the ALU / prefix-adder datapath. Two
// full-width operands arrive one after the other on a shared 8-bit bus. Each
// one is captured when a debounced push-button rises. The block then holds A,
// B, sel and cin as a stable registered operand set behind a valid/ready
// handshake.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   data_in    operand bus, sampled on each capture
//   sel_in     operation select, sampled together with B
//   cin_in     prefix-adder carry-in, sampled together with B
//   load_btn   raw asynchronous push-button; a debounced rising edge captures
//   abort      synchronous abort back to IDLE
//   op_ready   downstream accepts the operand set
//   a_out      registered operand A
//   b_out      registered operand B
//   sel_out    registered operation select
//   cin_out    registered carry-in
//   op_valid   operand set complete and stable
//   busy       state is not IDLE
//   state_out  state encoding: IDLE=00, WAIT_B=01, ISSUE=10
//   op_count   accepted handshakes, modulo 16
// ---------------------------------------------------------------------------
module alu_operand_sequencer #(
    parameter int W         = 8,
    parameter int SEL_W     = 3,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     data_in,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             cin_in,
    input  logic             load_btn,
    input  logic             abort,
    input  logic             op_ready,
    output logic [W-1:0]     a_out,
    output logic [W-1:0]     b_out,
    output logic [SEL_W-1:0] sel_out,
    output logic             cin_out,
    output logic             op_valid,
    output logic             busy,
    output logic [1:0]       state_out,
    output logic [3:0]       op_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT_B = 2'b01,
        ISSUE  = 2'b10
    } state_t;

    // Last count value before the debounced level is allowed to flip.
    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    state_t     state;
    logic       s1;
    logic       s2;
    logic       deb;
    logic       deb_q;
    logic [7:0] cnt;
    logic       load_pulse;

    // Two-flop synchronizer that brings the raw button into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= load_btn;
            s2 <= s1;
        end
    end

    // Debouncer: the synchronized level must differ from the debounced level
    // for DB_CYCLES consecutive cycles before it is accepted. Any return to
    // the current debounced level restarts the count, so short glitches are
    // discarded. deb_q keeps the previous debounced level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= 8'd0;
        end else begin
            deb_q <= deb;
            if (s2 == deb) begin
                cnt <= 8'd0;
            end else if (cnt == DB_LAST) begin
                deb <= s2;
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // One-cycle pulse on every debounced rising edge of the button.
    assign load_pulse = deb & ~deb_q;

    // Operand sequencer. Abort takes priority over both a capture and a
    // handshake in the same cycle. The operand registers only change on a
    // capture, so the downstream ALU result stays visible after the
    // handshake or an abort. A load pulse that arrives in ISSUE is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_out    <= '0;
            b_out    <= '0;
            sel_out  <= '0;
            cin_out  <= 1'b0;
            op_valid <= 1'b0;
            op_count <= 4'd0;
        end else if (abort) begin
            state    <= IDLE;
            op_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_pulse) begin
                        a_out <= data_in;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (load_pulse) begin
                        b_out    <= data_in;
                        sel_out  <= sel_in;
                        cin_out  <= cin_in;
                        op_valid <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        op_count <= op_count + 4'd1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    op_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Status outputs are straight decodes of the state register.
    assign busy      = (state != IDLE);
    assign state_out = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_sequencer
//
// Self-checking bench for alu_operand_sequencer. A transaction-level model
// tracks the expected operand set, state and handshake count from the
// block's rules. Button presses, glitches, backpressure, aborts and resets
// are driven with randomized data and compared against that model.
// ---------------------------------------------------------------------------
module tb_alu_operand_sequencer;

    localparam int W         = 8;
    localparam int SEL_W     = 3;
    localparam int DB_CYCLES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     data_in;
    logic [SEL_W-1:0] sel_in;
    logic             cin_in;
    logic             load_btn;
    logic             abort;
    logic             op_ready;
    logic [W-1:0]     a_out;
    logic [W-1:0]     b_out;
    logic [SEL_W-1:0] sel_out;
    logic             cin_out;
    logic             op_valid;
    logic             busy;
    logic [1:0]       state_out;
    logic [3:0]       op_count;

    int passed = 0;
    int total  = 0;

    // Reference model: 0 = IDLE, 1 = WAIT_B, 2 = ISSUE
    logic [W-1:0]     m_a;
    logic [W-1:0]     m_b;
    logic [SEL_W-1:0] m_sel;
    logic             m_cin;
    logic             m_valid;
    int               m_state;
    int               m_count;

    logic [27:0] obs;

    always #5 clk = ~clk;

    alu_operand_sequencer #(
        .W(W),
        .SEL_W(SEL_W),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .sel_in(sel_in),
        .cin_in(cin_in),
        .load_btn(load_btn),
        .abort(abort),
        .op_ready(op_ready),
        .a_out(a_out),
        .b_out(b_out),
        .sel_out(sel_out),
        .cin_out(cin_out),
        .op_valid(op_valid),
        .busy(busy),
        .state_out(state_out),
        .op_count(op_count)
    );

    assign obs = {a_out, b_out, sel_out, cin_out, op_valid, busy, state_out, op_count};

    function automatic logic [27:0] expv();
        logic busy_e;
        busy_e = (m_state != 0);
        return {m_a, m_b, m_sel, m_cin, m_valid, busy_e, 2'(m_state), 4'(m_count)};
    endfunction

    task automatic model_reset();
        m_a = '0; m_b = '0; m_sel = '0; m_cin = 1'b0;
        m_valid = 1'b0; m_state = 0; m_count = 0;
    endtask

    task automatic model_load(input logic [W-1:0] d, input logic [SEL_W-1:0] s, input logic c);
        if (m_state == 0) begin
            m_a = d;
            m_state = 1;
        end else if (m_state == 1) begin
            m_b = d; m_sel = s; m_cin = c;
            m_valid = 1'b1;
            m_state = 2;
        end
    endtask

    task automatic model_handshake();
        if (m_state == 2) begin
            m_valid = 1'b0;
            m_count = (m_count + 1) % 16;
            m_state = 0;
        end
    endtask

    task automatic model_abort();
        m_valid = 1'b0;
        m_state = 0;
    endtask

    // Clean press: button high long enough to debounce, op_ready optionally
    // high exactly at the capture edge, then a low period long enough for the
    // debounced level to fall again. Called at a negedge.
    task automatic press(input logic [W-1:0] d, input logic [SEL_W-1:0] s, input logic c,
                         input int hold, input bit rdy);
        data_in = d; sel_in = s; cin_in = c; load_btn = 1'b1;
        repeat (DB_CYCLES + 2) @(negedge clk);
        op_ready = rdy;
        @(negedge clk);
        op_ready = 1'b0;
        if (rdy && m_state == 2) model_handshake();
        else model_load(d, s, c);
        data_in = W'($urandom); sel_in = SEL_W'($urandom); cin_in = 1'($urandom);
        repeat (hold - (DB_CYCLES + 3)) @(negedge clk);
        load_btn = 1'b0;
        repeat (DB_CYCLES + 4) @(negedge clk);
    endtask

    task automatic handshake();
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        model_handshake();
    endtask

    task automatic test_reset();
        rst = 1'b1; data_in = '0; sel_in = '0; cin_in = 1'b0;
        load_btn = 1'b0; abort = 1'b0; op_ready = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (obs !== expv()) $display("[TB] FAIL reset_hold: got %h expected %h", obs, expv()); else passed++;
        end
        rst = 1'b0;
        @(negedge clk);
        total++; if (obs !== expv()) $display("[TB] FAIL reset_release: got %h expected %h", obs, expv()); else passed++;
    endtask

    task automatic test_normal_load();
        data_in = 8'hA5; sel_in = SEL_W'($urandom); cin_in = 1'($urandom); load_btn = 1'b1;
        repeat (DB_CYCLES + 2) @(negedge clk);
        total++; if (obs !== expv()) $display("[TB] FAIL pre_capture_a: got %h expected %h", obs, expv()); else passed++;
        @(negedge clk);
        model_load(8'hA5, '0, 1'b0);
        total++; if (obs !== expv()) $display("[TB] FAIL capture_a: got %h expected %h", obs, expv()); else passed++;
        data_in = W'($urandom);
        repeat (3) @(negedge clk);
        load_btn = 1'b0;
        repeat (DB_CYCLES + 4) @(negedge clk);
        total++; if (obs !== expv()) $display("[TB] FAIL a_retained: got %h expected %h", obs, expv()); else passed++;
        press(8'h3C, 3'b010, 1'b1, 7, 1'b0);
        total++; if (obs !== expv()) $display("[TB] FAIL capture_b: got %h expected %h", obs, expv()); else passed++;
        handshake();
        total++; if (obs !== expv()) $display("[TB] FAIL first_handshake: got %h expected %h", obs, expv()); else passed++;
    endtask

    task automatic test_random_transactions();
        for (int t = 0; t < 6; t++) begin
            int stall;
            press(W'($urandom), SEL_W'($urandom), 1'($urandom), 7 + $urandom_range(0, 4), 1'b0);
            total++; if (obs !== expv()) $display("[TB] FAIL rand_a: got %h expected %h", obs, expv()); else passed++;
            press(W'($urandom), SEL_W'($urandom), 1'($urandom), 7 + $urandom_range(0, 4), 1'b0);
            total++; if (obs !== expv()) $display("[TB] FAIL rand_b: got %h expected %h", obs, expv()); else passed++;
            stall = $urandom_range(0, 5);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                total++; if (obs !== expv()) $display("[TB] FAIL rand_stall: got %h expected %h", obs, expv()); else passed++;
            end
            handshake();
            total++; if (obs !== expv()) $display("[TB] FAIL rand_handshake: got %h expected %h", obs, expv()); else passed++;
        end
    endtask

    task automatic test_debounce();
        logic [W-1:0] d;
        for (int g = 0; g < 4; g++) begin
            int len;
            len = $urandom_range(1, DB_CYCLES - 1);
            data_in = W'($urandom); load_btn = 1'b1;
            repeat (len) @(negedge clk);
            load_btn = 1'b0;
            repeat (10) @(negedge clk);
            total++; if (obs !== expv()) $display("[TB] FAIL glitch_ignored: got %h expected %h", obs, expv()); else passed++;
        end
        d = W'($urandom);
        data_in = d; load_btn = 1'b1;
        repeat (10) @(negedge clk);
        load_btn = 1'b0;
        repeat (DB_CYCLES + 4) @(negedge clk);
        model_load(d, '0, 1'b0);
        total++; if (obs !== expv()) $display("[TB] FAIL long_hold_single: got %h expected %h", obs, expv()); else passed++;
        press(W'($urandom), SEL_W'($urandom), 1'($urandom), 8, 1'b0);
        handshake();
        total++; if (obs !== expv()) $display("[TB] FAIL debounce_txn_done: got %h expected %h", obs, expv()); else passed++;
    endtask

    task automatic test_backpressure_drop();
        press(W'($urandom), SEL_W'($urandom), 1'($urandom), 7, 1'b0);
        press(W'($urandom), SEL_W'($urandom), 1'($urandom), 7, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            data_in = W'($urandom); sel_in = SEL_W'($urandom); cin_in = 1'($urandom);
            total++; if (obs !== expv()) $display("[TB] FAIL backpressure_stable: got %h expected %h", obs, expv()); else passed++;
        end
        press(W'($urandom), SEL_W'($urandom), 1'($urandom), 9, 1'b0);
        total++; if (obs !== expv()) $display("[TB] FAIL issue_press_dropped: got %h expected %h", obs, expv()); else passed++;
        handshake();
        total++; if (obs !== expv()) $display("[TB] FAIL handshake_after_drop: got %h expected %h", obs, expv()); else passed++;
        press(W'($urandom), SEL_W'($urandom), 1'($urandom), 7, 1'b0);
        press(W'($urandom), SEL_W'($urandom), 1'($urandom), 7, 1'b0);
        press(W'($urandom), SEL_W'($urandom), 1'($urandom), 7, 1'b1);
        total++; if (obs !== expv()) $display("[TB] FAIL pulse_lost_with_ready: got %h expected %h", obs, expv()); else passed++;
    endtask

    task automatic test_abort();
        press(W'($urandom), SEL_W'($urandom), 1'($urandom), 7, 1'b0);
        data_in = W'($urandom); sel_in = SEL_W'($urandom); cin_in = 1'b1; load_btn = 1'b1;
        repeat (DB_CYCLES + 2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        model_abort();
        total++; if (obs !== expv()) $display("[TB] FAIL abort_vs_load: got %h expected %h", obs, expv()); else passed++;
        repeat (3) @(negedge clk);
        load_btn = 1'b0;
        repeat (DB_CYCLES + 4) @(negedge clk);
        total++; if (obs !== expv()) $display("[TB] FAIL abort_no_late_capture: got %h expected %h", obs, expv()); else passed++;
        press(W'($urandom), SEL_W'($urandom), 1'($urandom), 7, 1'b0);
        press(W'($urandom), SEL_W'($urandom), 1'($urandom), 7, 1'b0);
        abort = 1'b1; op_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; op_ready = 1'b0;
        model_abort();
        total++; if (obs !== expv()) $display("[TB] FAIL abort_vs_ready: got %h expected %h", obs, expv()); else passed++;
        op_ready = 1'b1;
        repeat (3) @(negedge clk);
        op_ready = 1'b0;
        total++; if (obs !== expv()) $display("[TB] FAIL ready_in_idle_ignored: got %h expected %h", obs, expv()); else passed++;
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        total++; if (obs !== expv()) $display("[TB] FAIL wrap_reset: got %h expected %h", obs, expv()); else passed++;
        for (int t = 0; t < 16; t++) begin
            press(W'($urandom), SEL_W'($urandom), 1'($urandom), 7 + $urandom_range(0, 2), 1'b0);
            press(W'($urandom), SEL_W'($urandom), 1'($urandom), 7 + $urandom_range(0, 2), 1'b0);
            handshake();
            total++; if (obs !== expv()) $display("[TB] FAIL wrap_txn: got %h expected %h", obs, expv()); else passed++;
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] d;
        press(W'($urandom), SEL_W'($urandom), 1'($urandom), 7, 1'b0);
        press(W'($urandom), SEL_W'($urandom), 1'($urandom), 7, 1'b0);
        total++; if (obs !== expv()) $display("[TB] FAIL issue_before_reset: got %h expected %h", obs, expv()); else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        total++; if (obs !== expv()) $display("[TB] FAIL mid_reset_clear: got %h expected %h", obs, expv()); else passed++;
        d = W'($urandom);
        data_in = d; load_btn = 1'b1; rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (obs !== expv()) $display("[TB] FAIL reset_with_button: got %h expected %h", obs, expv()); else passed++;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        load_btn = 1'b0;
        repeat (DB_CYCLES + 4) @(negedge clk);
        model_load(d, '0, 1'b0);
        total++; if (obs !== expv()) $display("[TB] FAIL held_button_one_load: got %h expected %h", obs, expv()); else passed++;
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_random_transactions();
        test_debounce();
        test_backpressure_drop();
        test_abort();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation exceeded time limit, got %0d of %0d passed", passed, total);
        $fatal(1, "[TB] timeout");
    end

endmodule
